// File: rtl/ifetch_responder.sv
// Fetch-side responder: issues instruction-memory reads for PCF, fills the F/D
// register, and drives StallF while handling redirects with a read still in flight.
module ifetch_responder #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  StallD,
    input  logic                  FlushD,
    output logic                  StallF,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  InstrValidD
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] drain_addr;
    logic [DATA_WIDTH-1:0] hold_instr;
    logic [DATA_WIDTH-1:0] hold_pc;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] pc_aligned;

    assign pc_aligned = {PCF[DATA_WIDTH-1:2], 2'b00};

    // Memory request and PC hold; a DRAIN request keeps its original address
    // even though the PC has already moved on to the redirect target.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_aligned;
        StallF   = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    StallF  = mem_ready ? (!FlushD && StallD) : !FlushD;
                end
                DRAIN: begin
                    mem_req  = 1'b1;
                    mem_addr = drain_addr;
                    StallF   = !FlushD;
                end
                HOLD: begin
                    StallF = !FlushD && StallD;
                end
                default: ;
            endcase
        end
    end

    // State and F/D pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            drain_addr  <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            hold_valid  <= 1'b0;
            InstrD      <= NOP_INSTR;
            PCD         <= '0;
            PCPlus4D    <= PC_STEP;
            InstrValidD <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        if (FlushD) begin
                            InstrD      <= NOP_INSTR;
                            InstrValidD <= 1'b0;
                        end else if (StallD) begin
                            hold_instr <= mem_rdata;
                            hold_pc    <= PCF;
                            hold_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            InstrD      <= mem_rdata;
                            PCD         <= PCF;
                            PCPlus4D    <= PCF + PC_STEP;
                            InstrValidD <= 1'b1;
                        end
                    end else if (FlushD) begin
                        drain_addr  <= pc_aligned;
                        state       <= DRAIN;
                        InstrD      <= NOP_INSTR;
                        InstrValidD <= 1'b0;
                    end else if (!StallD) begin
                        InstrD      <= NOP_INSTR;
                        InstrValidD <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (FlushD || !StallD) begin
                        InstrD      <= NOP_INSTR;
                        InstrValidD <= 1'b0;
                    end
                    if (mem_ready) begin
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    if (FlushD) begin
                        hold_valid  <= 1'b0;
                        InstrD      <= NOP_INSTR;
                        InstrValidD <= 1'b0;
                        state       <= FETCH;
                    end else if (!StallD) begin
                        hold_valid  <= 1'b0;
                        InstrD      <= hold_instr;
                        PCD         <= hold_pc;
                        PCPlus4D    <= hold_pc + PC_STEP;
                        InstrValidD <= hold_valid;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: zero-wait streaming, wait states, HOLD,
// redirect during an outstanding read, wrap-around and reset out of DRAIN.
module tb_ifetch_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        StallD;
    logic        FlushD;
    logic        StallF;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        InstrValidD;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_responder dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .StallF     (StallF),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .InstrValidD(InstrValidD)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCF = 32'h40; StallD = 1'b0; FlushD = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL reset_stallf got=%b exp=0", StallF); end
        tick();
        tick();
        n_checks++; if (InstrD !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", InstrD, NOP); end
        n_checks++; if (PCD !== 32'h0) begin n_fail++; $display("FAIL reset_pcd got=%h exp=0", PCD); end
        n_checks++; if (PCPlus4D !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus4 got=%h exp=4", PCPlus4D); end
        n_checks++; if (InstrValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", InstrValidD); end
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            PCF = 32'(i * 4); mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL zw_mem_req[%0d] got=%b exp=1", i, mem_req); end
            n_checks++; if (mem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, mem_addr, 32'(i * 4)); end
            n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL zw_stallf[%0d] got=%b exp=0", i, StallF); end
            tick();
            n_checks++; if (InstrD !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL zw_instr[%0d] got=%h exp=%h", i, InstrD, 32'hA000_0000 + 32'(i)); end
            n_checks++; if (PCD !== 32'(i * 4)) begin n_fail++; $display("FAIL zw_pcd[%0d] got=%h exp=%h", i, PCD, 32'(i * 4)); end
            n_checks++; if (PCPlus4D !== 32'(i * 4 + 4)) begin n_fail++; $display("FAIL zw_pcplus4[%0d] got=%h exp=%h", i, PCPlus4D, 32'(i * 4 + 4)); end
            n_checks++; if (InstrValidD !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, InstrValidD); end
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 2; i++) begin
            PCF = 32'h10; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
            #1;
            n_checks++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL ws_stallf[%0d] got=%b exp=1", i, StallF); end
            n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL ws_addr[%0d] got=%h exp=10", i, mem_addr); end
            tick();
            n_checks++; if (InstrValidD !== 1'b0) begin n_fail++; $display("FAIL ws_valid[%0d] got=%b exp=0", i, InstrValidD); end
            n_checks++; if (InstrD !== NOP) begin n_fail++; $display("FAIL ws_instr[%0d] got=%h exp=%h", i, InstrD, NOP); end
        end
        mem_ready = 1'b1; mem_rdata = 32'h0010_0113;
        #1;
        n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL ws_done_stallf got=%b exp=0", StallF); end
        tick();
        n_checks++; if (PCD !== 32'h10) begin n_fail++; $display("FAIL ws_pcd got=%h exp=10", PCD); end
        n_checks++; if (PCPlus4D !== 32'h14) begin n_fail++; $display("FAIL ws_pcplus4 got=%h exp=14", PCPlus4D); end
        n_checks++; if (InstrD !== 32'h0010_0113) begin n_fail++; $display("FAIL ws_instr got=%h exp=00100113", InstrD); end
        n_checks++; if (InstrValidD !== 1'b1) begin n_fail++; $display("FAIL ws_done_valid got=%b exp=1", InstrValidD); end
    endtask

    task automatic test_hold();
        PCF = 32'h20; mem_ready = 1'b1; mem_rdata = 32'h0050_0093; StallD = 1'b1;
        #1;
        n_checks++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL hold_cap_stallf got=%b exp=1", StallF); end
        tick();
        n_checks++; if (InstrD !== 32'h0010_0113) begin n_fail++; $display("FAIL hold_fd_instr got=%h exp=00100113", InstrD); end
        n_checks++; if (PCD !== 32'h10) begin n_fail++; $display("FAIL hold_fd_pcd got=%h exp=10", PCD); end
        mem_rdata = 32'hDEAD_0000;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_mem_req got=%b exp=0", mem_req); end
        n_checks++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL hold_stallf got=%b exp=1", StallF); end
        tick();
        n_checks++; if (InstrD !== 32'h0010_0113) begin n_fail++; $display("FAIL hold_keep_instr got=%h exp=00100113", InstrD); end
        n_checks++; if (InstrValidD !== 1'b1) begin n_fail++; $display("FAIL hold_keep_valid got=%b exp=1", InstrValidD); end
        StallD = 1'b0;
        #1;
        n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL hold_rel_stallf got=%b exp=0", StallF); end
        tick();
        n_checks++; if (InstrD !== 32'h0050_0093) begin n_fail++; $display("FAIL hold_rel_instr got=%h exp=00500093", InstrD); end
        n_checks++; if (PCD !== 32'h20) begin n_fail++; $display("FAIL hold_rel_pcd got=%h exp=20", PCD); end
        n_checks++; if (PCPlus4D !== 32'h24) begin n_fail++; $display("FAIL hold_rel_pcplus4 got=%h exp=24", PCPlus4D); end
        PCF = 32'h24; mem_rdata = 32'h0020_0193;
        #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL hold_next_req got=%b exp=1", mem_req); end
        n_checks++; if (mem_addr !== 32'h24) begin n_fail++; $display("FAIL hold_next_addr got=%h exp=24", mem_addr); end
        tick();
        n_checks++; if (PCD !== 32'h24) begin n_fail++; $display("FAIL hold_next_pcd got=%h exp=24", PCD); end
    endtask

    task automatic test_flush_drain();
        PCF = 32'h30; mem_ready = 1'b0; FlushD = 1'b1; mem_rdata = 32'hBAD0_0030;
        #1;
        n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL fl_stallf got=%b exp=0", StallF); end
        n_checks++; if (mem_addr !== 32'h30) begin n_fail++; $display("FAIL fl_addr got=%h exp=30", mem_addr); end
        tick();
        n_checks++; if (InstrValidD !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%b exp=0", InstrValidD); end
        PCF = 32'h100; FlushD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            n_checks++; if (mem_addr !== 32'h30) begin n_fail++; $display("FAIL dr_addr[%0d] got=%h exp=30", i, mem_addr); end
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL dr_req[%0d] got=%b exp=1", i, mem_req); end
            n_checks++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL dr_stallf[%0d] got=%b exp=1", i, StallF); end
            tick();
            n_checks++; if (InstrValidD !== 1'b0) begin n_fail++; $display("FAIL dr_valid[%0d] got=%b exp=0", i, InstrValidD); end
        end
        mem_ready = 1'b1; mem_rdata = 32'h0030_0213;
        #1;
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL dr_next_addr got=%h exp=100", mem_addr); end
        tick();
        n_checks++; if (InstrD !== 32'h0030_0213) begin n_fail++; $display("FAIL dr_next_instr got=%h exp=00300213", InstrD); end
        n_checks++; if (PCD !== 32'h100) begin n_fail++; $display("FAIL dr_next_pcd got=%h exp=100", PCD); end
        n_checks++; if (InstrValidD !== 1'b1) begin n_fail++; $display("FAIL dr_next_valid got=%b exp=1", InstrValidD); end
    endtask

    task automatic test_flush_stall_hold();
        PCF = 32'h200; mem_ready = 1'b1; StallD = 1'b1; mem_rdata = 32'h0040_0293;
        tick();
        FlushD = 1'b1;
        #1;
        n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL fsh_stallf got=%b exp=0", StallF); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fsh_mem_req got=%b exp=0", mem_req); end
        tick();
        n_checks++; if (InstrValidD !== 1'b0) begin n_fail++; $display("FAIL fsh_valid got=%b exp=0", InstrValidD); end
        n_checks++; if (InstrD !== NOP) begin n_fail++; $display("FAIL fsh_instr got=%h exp=%h", InstrD, NOP); end
        FlushD = 1'b0; StallD = 1'b0; PCF = 32'h208;
        #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fsh_fetch_req got=%b exp=1", mem_req); end
        n_checks++; if (mem_addr !== 32'h208) begin n_fail++; $display("FAIL fsh_fetch_addr got=%h exp=208", mem_addr); end
        tick();
    endtask

    task automatic test_wrap_align();
        PCF = 32'hFFFF_FFFC; mem_ready = 1'b1; mem_rdata = 32'h0050_0313;
        tick();
        n_checks++; if (PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL wrap_pcplus4 got=%h exp=0", PCPlus4D); end
        n_checks++; if (PCD !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pcd got=%h exp=fffffffc", PCD); end
        PCF = 32'h0000_0106;
        #1;
        n_checks++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL align_addr got=%h exp=104", mem_addr); end
        tick();
    endtask

    task automatic test_reset_drain();
        PCF = 32'h300; mem_ready = 1'b0; FlushD = 1'b1;
        tick();
        FlushD = 1'b0; PCF = 32'h400;
        #1;
        n_checks++; if (mem_addr !== 32'h300) begin n_fail++; $display("FAIL rd_drain_addr got=%h exp=300", mem_addr); end
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rd_mem_req got=%b exp=0", mem_req); end
        n_checks++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL rd_stallf got=%b exp=0", StallF); end
        tick();
        n_checks++; if (InstrD !== NOP) begin n_fail++; $display("FAIL rd_instr got=%h exp=%h", InstrD, NOP); end
        n_checks++; if (InstrValidD !== 1'b0) begin n_fail++; $display("FAIL rd_valid got=%b exp=0", InstrValidD); end
        n_checks++; if (PCD !== 32'h0) begin n_fail++; $display("FAIL rd_pcd got=%h exp=0", PCD); end
        reset = 1'b0;
        #1;
        n_checks++; if (mem_addr !== 32'h400) begin n_fail++; $display("FAIL rd_fetch_addr got=%h exp=400", mem_addr); end
        n_checks++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL rd_fetch_stallf got=%b exp=1", StallF); end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_hold();
        test_flush_drain();
        test_flush_stall_hold();
        test_wrap_align();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
